// File: rtl/flash_config_loader.sv
// Flash configuration loader: wakes a SPI NOR flash (0xAB), issues a READ (0x03)
// at START_ADDR, takes a big-endian 32-bit word count N from the stream and then
// emits N big-endian 32-bit configuration words, each qualified by a strobe.
module flash_config_loader #(
  parameter int unsigned CLK_DIV    = 2,
  parameter logic [23:0] START_ADDR = 24'h000000,
  parameter logic [31:0] MAX_WORDS  = 32'h0001_0000,
  parameter int unsigned RES_WAIT   = 48
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        boot_o,
  output logic        sck_o,
  output logic        cs_o,
  output logic        pico_o,
  input  logic        poci_i,
  output logic [31:0] write_data_o,
  output logic        write_strobe_o
);

  localparam logic [7:0]  DivMax  = 8'(CLK_DIV - 1);
  localparam logic [31:0] GapMax  = 32'(RES_WAIT - 1);
  localparam logic [7:0]  CmdWake = 8'hAB;
  localparam logic [7:0]  CmdRead = 8'h03;

  typedef enum logic [3:0] {
    StIdle, StWake, StWakeGap, StCmd, StAddr, StHeader, StData, StDone, StError
  } state_e;

  state_e state_q, state_d;

  logic [7:0]  div_q, div_d;     // clk_i cycles within the current SCK half-period
  logic        sck_q, sck_d;
  logic [2:0]  bit_q, bit_d;     // bit index within the current byte
  logic [1:0]  byte_q, byte_d;   // byte index within the current field
  logic [7:0]  tx_q, tx_d;       // outgoing byte, MSB drives pico_o
  logic [31:0] rx_q, rx_d;       // last 32 bits received
  logic [31:0] n_q, n_d;         // header word count
  logic [31:0] word_q, word_d;   // words completed so far
  logic [31:0] gap_q, gap_d;
  logic        last_rise_q, last_rise_d;
  logic        strobe_q, strobe_d;
  logic [31:0] data_q, data_d;
  logic        cs_q, cs_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic spi_active, tick, rise, fall, byte_end, gap_done, start_ok, hdr_bad, last_word;

  assign spi_active = state_q inside {StWake, StCmd, StAddr, StHeader, StData};
  assign tick       = spi_active && (div_q == DivMax);
  assign rise       = tick && !sck_q;
  assign fall       = tick && sck_q;
  assign byte_end   = fall && (bit_q == 3'd7);
  assign gap_done   = (state_q == StWakeGap) && (gap_q == GapMax);
  assign start_ok   = start_i && (state_q inside {StIdle, StDone, StError});
  assign hdr_bad    = (rx_q == '0) || (rx_q == '1) || (rx_q > MAX_WORDS);
  // N is never zero in DATA, so N-1 cannot wrap
  assign last_word  = (word_q == (n_q - 32'd1));

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; transitions between SPI fields happen only on byte boundaries
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StError: if (start_i) state_d = StWake;
      StWake:    if (byte_end) state_d = StWakeGap;
      StWakeGap: if (gap_done) state_d = StCmd;
      StCmd:     if (byte_end) state_d = StAddr;
      StAddr:    if (byte_end && (byte_q == 2'd2)) state_d = StHeader;
      StHeader:  if (byte_end && (byte_q == 2'd3)) state_d = hdr_bad ? StError : StData;
      StData:    if (byte_end && (byte_q == 2'd3) && last_word) state_d = StDone;
      default:   state_d = StIdle;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy_o = 1'b1;
    if (state_q inside {StIdle, StDone, StError}) busy_o = 1'b0;
  end

  // Datapath next-state: SCK divider, shifters, counters and flags
  always_comb begin
    div_d       = div_q;
    sck_d       = sck_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    n_d         = n_q;
    word_d      = word_q;
    gap_d       = '0;
    last_rise_d = (state_q == StData) && rise && (bit_q == 3'd7) && (byte_q == 2'd3);
    strobe_d    = last_rise_q;
    data_d      = data_q;
    done_d      = done_q;
    error_d     = error_q;
    cs_d        = !(state_d inside {StWake, StCmd, StAddr, StHeader, StData});

    if (spi_active) begin
      div_d = tick ? 8'd0 : div_q + 8'd1;
      if (tick) sck_d = ~sck_q;
      if (rise) rx_d = {rx_q[30:0], poci_i};
      // Next bit is presented on the falling edge, a full low phase before the rise
      if (fall) begin
        bit_d = bit_q + 3'd1;
        tx_d  = {tx_q[6:0], 1'b0};
      end
      if (byte_end) begin
        byte_d = (state_d != state_q) ? 2'd0 : byte_q + 2'd1;
        if (state_q == StCmd) begin
          tx_d = START_ADDR[23:16];
        end else if ((state_q == StAddr) && (byte_q == 2'd0)) begin
          tx_d = START_ADDR[15:8];
        end else if ((state_q == StAddr) && (byte_q == 2'd1)) begin
          tx_d = START_ADDR[7:0];
        end
        if ((state_q == StHeader) && (byte_q == 2'd3)) n_d = rx_q;
        if ((state_q == StData) && (byte_q == 2'd3)) word_d = word_q + 32'd1;
      end
    end else begin
      div_d  = '0;
      sck_d  = 1'b0;
      bit_d  = '0;
      byte_d = '0;
    end

    if (state_q == StWakeGap) gap_d = gap_q + 32'd1;
    if (gap_done) tx_d = CmdRead;

    if (start_ok) begin
      tx_d    = CmdWake;
      word_d  = '0;
      done_d  = 1'b0;
      error_d = 1'b0;
    end

    if ((state_d == StDone) && (state_q != StDone)) done_d = 1'b1;
    if (state_d == StError) error_d = 1'b1;

    // rx_q holds the complete word one cycle after its last bit was sampled
    if (last_rise_q) data_d = rx_q;
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      div_q       <= '0;
      sck_q       <= 1'b0;
      bit_q       <= '0;
      byte_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      n_q         <= '0;
      word_q      <= '0;
      gap_q       <= '0;
      last_rise_q <= 1'b0;
      strobe_q    <= 1'b0;
      data_q      <= '0;
      cs_q        <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      div_q       <= div_d;
      sck_q       <= sck_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      n_q         <= n_d;
      word_q      <= word_d;
      gap_q       <= gap_d;
      last_rise_q <= last_rise_d;
      strobe_q    <= strobe_d;
      data_q      <= data_d;
      cs_q        <= cs_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign sck_o          = sck_q;
  assign cs_o           = cs_q;
  assign pico_o         = tx_q[7];
  assign write_data_o   = data_q;
  assign write_strobe_o = strobe_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign boot_o         = done_q;

endmodule

// File: doc/flash_config_loader.md
FLASH_CONFIG_LOADER -- requirements
Module: flash_config_loader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning SCK half-period in clk_i cycles (legal range 1..255).
REQ-002 SHALL have parameter START_ADDR, default 24'h000000, meaning flash byte address of the bitstream header.
REQ-003 SHALL have parameter MAX_WORDS, default 32'h0001_0000, meaning the largest legal header word count.
REQ-004 SHALL have parameter RES_WAIT, default 48, meaning clk_i cycles with CS high after the wake command.
REQ-005 SHALL have port clk_i, input, 1, the single clock for all logic.
REQ-006 SHALL have port reset_n_i, input, 1; reset is synchronous and active-low.
REQ-007 SHALL have port start_i, input, 1, a load request that is sampled high for one cycle in IDLE/DONE/ERROR.
REQ-008 SHALL have port busy_o, output, 1, high while a load is in progress.
REQ-009 SHALL have port done_o, output, 1, sticky flag for a successful load.
REQ-010 SHALL have port error_o, output, 1, sticky flag for a bad header.
REQ-011 SHALL have port boot_o, output, 1, equal to done_o; it releases the fabric from boot.
REQ-012 SHALL have ports sck_o (output, 1), cs_o (output, 1, active-low chip select), pico_o (output, 1) and poci_i (input, 1), forming SPI mode 0.
REQ-013 SHALL have port write_data_o, output, 32, the assembled configuration word.
REQ-014 SHALL have port write_strobe_o, output, 1, a one-cycle pulse that qualifies write_data_o.

Function
REQ-015 SHALL implement states IDLE, WAKE, WAKE_GAP, CMD, ADDR, HEADER, DATA, DONE and ERROR.
REQ-016 SHALL leave IDLE/DONE/ERROR for WAKE on start_i=1, clearing done_o, error_o and the word counter; start_i SHALL be ignored in all other states.
REQ-017 SHALL shift each byte MSB first: pico_o changes while SCK is low (setup, CLK_DIV cycles before the rise); poci_i is sampled in the cycle of each SCK rising edge.
REQ-018 SHALL use one byte time of exactly 16*CLK_DIV clk_i cycles; sck_o SHALL idle low.
REQ-019 In WAKE, SHALL send byte 8'hAB with cs_o low, then enter WAKE_GAP.
REQ-020 In WAKE_GAP, SHALL drive cs_o high for exactly RES_WAIT cycles, then enter CMD.
REQ-021 In CMD, SHALL send 8'h03 with cs_o low; in ADDR, SHALL send START_ADDR as 3 bytes, MSB byte first; cs_o SHALL stay low continuously from CMD through DATA.
REQ-022 While receiving, pico_o SHALL be held 0.
REQ-023 In HEADER, SHALL receive 4 bytes, big-endian, into a 32-bit word count N.
REQ-024 If N==0, N==32'hFFFF_FFFF or N>MAX_WORDS, SHALL enter ERROR; the header SHALL NOT be strobed.
REQ-025 In DATA, SHALL receive N words with byte 0 to [31:24] and byte 3 to [7:0].
REQ-026 write_strobe_o SHALL pulse for one cycle, 1 cycle after the last SCK rise of each word's 4th byte, and write_data_o SHALL hold stable until the next strobe.
REQ-027 After the Nth strobe, SHALL drive cs_o high and sck_o low, then enter DONE in the same cycle.
REQ-028 On entering DONE, SHALL set done_o.
REQ-029 In ERROR, SHALL drive cs_o high and set error_o.
REQ-030 done_o and error_o SHALL never be high together.
REQ-031 busy_o SHALL be 1 in all states except IDLE, DONE and ERROR.
REQ-032 The word counter SHALL be 32 bits and SHALL compare against N exactly, with no wrap.

Reset
REQ-033 While reset_n_i=0 at a clk_i rising edge, SHALL set state=IDLE, cs_o=1, sck_o=0, pico_o=0, write_strobe_o=0, write_data_o=0, busy_o=0, done_o=0, error_o=0 and boot_o=0.
REQ-034 Reset asserted mid-transfer SHALL take effect on the next edge; no further strobe SHALL be issued, and cs_o SHALL rise on that edge.

Verification
REQ-035 Flash model header 32'h0000_0002 with data 11223344 AABBCCDD, start_i pulse -> bus shows AB, gap of 48 cycles, 03 00 00 00; 2 strobes with 32'h11223344 then 32'hAABBCCDD; done_o=boot_o=1; cs_o=1.
REQ-036 Header 32'hFFFF_FFFF (erased flash) -> error_o=1, no strobe, cs_o=1, boot_o=0.
REQ-037 Header MAX_WORDS+1 -> ERROR; header exactly MAX_WORDS (shrink MAX_WORDS=4 in test) -> 4 strobes, then DONE.
REQ-038 With CLK_DIV=3, measure the interval between strobes -> exactly 4*16*3=192 cycles within DATA.
REQ-039 start_i pulsed during DATA -> ignored; start_i after DONE -> done_o clears next cycle and the sequence repeats identically.
REQ-040 reset_n_i low for 1 cycle during the 2nd data byte -> cs_o=1 and sck_o=0 on that edge; no strobe afterwards; outputs take the REQ-033 values.
